operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Initiator side of the register_file interface: drives the two read ports and the write port.
//  Accepts decoded instructions (src0, src1, dst) over valid/ready and reads both operands.
//  Bypasses same-cycle writebacks and stalls RAW hazards with a per-register busy scoreboard.
//  Presents operands to the execute stage over valid/ready; forwards execute writebacks into the file.
// PARAMETERS
//  ADDR_BITS  3  register address width; NUM_REGS = 1<<ADDR_BITS (localparam)
//  DATA_BITS  8  register/operand data width
// PORTS
//  clk           in   1          single clock, all state on rising edge
//  reset         in   1          synchronous, active-low (0 = reset)
//  issue_valid   in   1          instruction offered
//  issue_ready   out  1          instruction accepted when valid&ready at clk edge
//  issue_src0    in   ADDR_BITS  source register 0
//  issue_src1    in   ADDR_BITS  source register 1
//  issue_dst     in   ADDR_BITS  destination register
//  issue_wb      in   1          1 = instruction will write issue_dst
//  rd0_addr      out  ADDR_BITS  to register_file rd0_addr
//  rd0_enable    out  1          to register_file rd0_enable
//  rd0_data      in   DATA_BITS  from register_file (combinational, same cycle)
//  rd1_addr      out  ADDR_BITS  to register_file rd1_addr
//  rd1_enable    out  1          to register_file rd1_enable
//  rd1_data      in   DATA_BITS  from register_file (combinational, same cycle)
//  wr_addr       out  ADDR_BITS  to register_file wr_addr
//  wr_enable     out  1          to register_file wr_enable
//  wr_data       out  DATA_BITS  to register_file wr_data
//  ex_valid      out  1          operands valid to execute stage
//  ex_ready      in   1          execute stage accepts
//  ex_op0        out  DATA_BITS  operand 0
//  ex_op1        out  DATA_BITS  operand 1
//  ex_dst        out  ADDR_BITS  destination passed through
//  ex_wb         out  1          writeback flag passed through
//  wb_valid      in   1          execute result write request
//  wb_addr       in   ADDR_BITS  result register
//  wb_data       in   DATA_BITS  result value
//  busy          out  NUM_REGS   scoreboard: bit i = write to ri pending
// BEHAVIOUR
//  Reset (reset=0 at edge): state=IDLE, busy=0, ex_valid=0, ex_op0/op1/dst/wb=0, latched instr=0.
//   While reset=0: issue_ready=0, rd0/rd1_enable=0, wr_enable=0 (wb_valid ignored, not written).
//   Reset mid-operation discards in-flight instruction and all pending busy bits.
//  FSM: IDLE, FETCH, PRESENT.
//   IDLE: issue_ready=1; handshake latches src0/src1/dst/wb -> FETCH.
//   FETCH: rdN_addr=latched srcN, rdN_enable=1 (both 0 in other states, addrs hold).
//    hazard = (busy[src0] & !(wb_valid & wb_addr==src0)) | same for src1.
//    hazard -> stay FETCH (issue_ready=0). Else capture opN = (wb_valid & wb_addr==srcN) ? wb_data
//    : rdN_data; set busy[dst] if wb; -> PRESENT.
//   PRESENT: ex_valid=1; ex_* stable until ex_ready. issue_ready=ex_ready.
//    ex_ready & issue_valid -> latch new instr, FETCH (back-to-back); ex_ready only -> IDLE.
//  Latency: issue handshake edge N -> FETCH cycle N+1 -> ex_valid from cycle N+2 (no hazard).
//   Sustained throughput 1 instruction / 2 cycles.
//  Writeback: wr_enable=wb_valid, wr_addr=wb_addr, wr_data=wb_data combinationally (data lands at
//   edge); busy[wb_addr] cleared at same edge. wb to non-busy register still written, no error.
//  Same-edge set (FETCH dst) and clear (wb_addr) of one bit: set wins -> busy=1.
//  src0==src1 legal; both ports read same register. dst==src legal (reads old value).
//  Widths: no arithmetic; all addresses compared full ADDR_BITS, no wrap.
// TESTING
//  1 reset=0 two cycles, wb_valid=1 addr=2 -> wr_enable=0, ex_valid=0, busy=0; after release issue_ready=1.
//  2 wb r1=0x12, r2=0x34; issue src0=1 src1=2 dst=3 wb=1 -> ex_valid 2 cycles later, op0=0x12
//    op1=0x34 ex_dst=3, busy=8'h08.
//  3 busy[3]=1, issue src0=3 -> FETCH stall, issue_ready=0, rd0_enable=1; wb addr=3 data=0x5A ->
//    op0=0x5A bypassed, ex_valid next cycle, busy[3]=0.
//  4 PRESENT with ex_ready=0 for 5 cycles -> ex_valid=1, ops/dst stable, issue_ready=0; then
//    ex_ready=1 & issue_valid=1 -> FETCH next cycle, no IDLE bubble.
//  5 FETCH dst=4 wb=1 while wb_valid addr=4 -> busy[4]=1 after edge, r4 written.
//  6 reset=0 during stalled FETCH with busy=8'hFF -> IDLE, busy=0, ex_valid=0.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads both sources from the register file, bypasses same-cycle
// writebacks, stalls on pending writes via a per-register busy scoreboard.
module operand_fetch #(
    parameter int ADDR_BITS = 3,
    parameter int DATA_BITS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [ADDR_BITS-1:0]        issue_src0,
    input  logic [ADDR_BITS-1:0]        issue_src1,
    input  logic [ADDR_BITS-1:0]        issue_dst,
    input  logic                        issue_wb,
    output logic [ADDR_BITS-1:0]        rd0_addr,
    output logic                        rd0_enable,
    input  logic [DATA_BITS-1:0]        rd0_data,
    output logic [ADDR_BITS-1:0]        rd1_addr,
    output logic                        rd1_enable,
    input  logic [DATA_BITS-1:0]        rd1_data,
    output logic [ADDR_BITS-1:0]        wr_addr,
    output logic                        wr_enable,
    output logic [DATA_BITS-1:0]        wr_data,
    output logic                        ex_valid,
    input  logic                        ex_ready,
    output logic [DATA_BITS-1:0]        ex_op0,
    output logic [DATA_BITS-1:0]        ex_op1,
    output logic [ADDR_BITS-1:0]        ex_dst,
    output logic                        ex_wb,
    input  logic                        wb_valid,
    input  logic [ADDR_BITS-1:0]        wb_addr,
    input  logic [DATA_BITS-1:0]        wb_data,
    output logic [(1<<ADDR_BITS)-1:0]   busy
);

    localparam int NUM_REGS = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   src0_q, src0_d, src1_q, src1_d, dst_q, dst_d;
    logic                   wb_q, wb_d;
    logic [NUM_REGS-1:0]    busy_q, busy_d;
    logic                   ex_valid_q, ex_valid_d;
    logic [DATA_BITS-1:0]   ex_op0_q, ex_op0_d, ex_op1_q, ex_op1_d;
    logic [ADDR_BITS-1:0]   ex_dst_q, ex_dst_d;
    logic                   ex_wb_q, ex_wb_d;

    logic                   wb_hit0, wb_hit1, hazard;

    // A pending write that lands this very edge is satisfied by the bypass, so it is not a hazard.
    assign wb_hit0 = wb_valid && (wb_addr == src0_q);
    assign wb_hit1 = wb_valid && (wb_addr == src1_q);
    assign hazard  = (busy_q[src0_q] && !wb_hit0) || (busy_q[src1_q] && !wb_hit1);

    always_comb begin
        state_d    = state_q;
        src0_d     = src0_q;
        src1_d     = src1_q;
        dst_d      = dst_q;
        wb_d       = wb_q;
        busy_d     = busy_q;
        ex_valid_d = ex_valid_q;
        ex_op0_d   = ex_op0_q;
        ex_op1_d   = ex_op1_q;
        ex_dst_d   = ex_dst_q;
        ex_wb_d    = ex_wb_q;

        if (wb_valid) begin
            busy_d[wb_addr] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (issue_valid) begin
                    src0_d  = issue_src0;
                    src1_d  = issue_src1;
                    dst_d   = issue_dst;
                    wb_d    = issue_wb;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (!hazard) begin
                    ex_op0_d   = wb_hit0 ? wb_data : rd0_data;
                    ex_op1_d   = wb_hit1 ? wb_data : rd1_data;
                    ex_dst_d   = dst_q;
                    ex_wb_d    = wb_q;
                    ex_valid_d = 1'b1;
                    // Applied after the writeback clear so a same-edge set wins.
                    if (wb_q) begin
                        busy_d[dst_q] = 1'b1;
                    end
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ex_ready) begin
                    ex_valid_d = 1'b0;
                    if (issue_valid) begin
                        src0_d  = issue_src0;
                        src1_d  = issue_src1;
                        dst_d   = issue_dst;
                        wb_d    = issue_wb;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            src0_q     <= '0;
            src1_q     <= '0;
            dst_q      <= '0;
            wb_q       <= 1'b0;
            busy_q     <= '0;
            ex_valid_q <= 1'b0;
            ex_op0_q   <= '0;
            ex_op1_q   <= '0;
            ex_dst_q   <= '0;
            ex_wb_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            src0_q     <= src0_d;
            src1_q     <= src1_d;
            dst_q      <= dst_d;
            wb_q       <= wb_d;
            busy_q     <= busy_d;
            ex_valid_q <= ex_valid_d;
            ex_op0_q   <= ex_op0_d;
            ex_op1_q   <= ex_op1_d;
            ex_dst_q   <= ex_dst_d;
            ex_wb_q    <= ex_wb_d;
        end
    end

    assign issue_ready = reset && ((state_q == IDLE) || ((state_q == PRESENT) && ex_ready));
    assign rd0_addr    = src0_q;
    assign rd1_addr    = src1_q;
    assign rd0_enable  = reset && (state_q == FETCH);
    assign rd1_enable  = reset && (state_q == FETCH);
    assign wr_enable   = reset && wb_valid;
    assign wr_addr     = wb_addr;
    assign wr_data     = wb_data;
    assign ex_valid    = ex_valid_q;
    assign ex_op0      = ex_op0_q;
    assign ex_op1      = ex_op1_q;
    assign ex_dst      = ex_dst_q;
    assign ex_wb       = ex_wb_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios, then random traffic scored against an
// in-order architectural register model.
module tb_operand_fetch;

    localparam int ADDR_BITS = 3;
    localparam int DATA_BITS = 8;
    localparam int NUM_REGS  = 1 << ADDR_BITS;
    localparam int NUM_RAND  = 200;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   issue_valid, issue_ready, issue_wb;
    logic [ADDR_BITS-1:0]   issue_src0, issue_src1, issue_dst;
    logic [ADDR_BITS-1:0]   rd0_addr, rd1_addr, wr_addr, ex_dst, wb_addr;
    logic                   rd0_enable, rd1_enable, wr_enable;
    logic [DATA_BITS-1:0]   rd0_data, rd1_data, wr_data, ex_op0, ex_op1, wb_data;
    logic                   ex_valid, ex_ready, ex_wb, wb_valid;
    logic [NUM_REGS-1:0]    busy;

    typedef struct {
        logic [DATA_BITS-1:0] op0;
        logic [DATA_BITS-1:0] op1;
        logic [ADDR_BITS-1:0] dst;
        logic                 wb;
        logic [DATA_BITS-1:0] wdata;
    } exp_t;

    typedef struct {
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } wbreq_t;

    exp_t                 expq[$];
    wbreq_t               wbq[$];
    logic [DATA_BITS-1:0] rf   [NUM_REGS];
    logic [DATA_BITS-1:0] arch [NUM_REGS];
    int                   pending [NUM_REGS];
    int                   checks = 0;
    int                   passes = 0;
    bit                   rand_mode = 1'b0;
    bit                   issue_done = 1'b0;
    bit                   init_rf = 1'b1;

    always #5 clk = ~clk;

    operand_fetch #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_src0(issue_src0), .issue_src1(issue_src1),
        .issue_dst(issue_dst), .issue_wb(issue_wb),
        .rd0_addr(rd0_addr), .rd0_enable(rd0_enable), .rd0_data(rd0_data),
        .rd1_addr(rd1_addr), .rd1_enable(rd1_enable), .rd1_data(rd1_data),
        .wr_addr(wr_addr), .wr_enable(wr_enable), .wr_data(wr_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_op0(ex_op0), .ex_op1(ex_op1), .ex_dst(ex_dst), .ex_wb(ex_wb),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy)
    );

    function automatic logic [DATA_BITS-1:0] rf_init_val(input int i);
        return DATA_BITS'(i * 17 + 1);
    endfunction

    // Register file model: combinational reads, write lands at the clock edge.
    assign rd0_data = rf[rd0_addr];
    assign rd1_data = rf[rd1_addr];

    always @(posedge clk) begin
        if (init_rf) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= rf_init_val(i);
        end else if (wr_enable) begin
            rf[wr_addr] <= wr_data;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [ADDR_BITS-1:0] s0, input logic [ADDR_BITS-1:0] s1,
                                  input logic [ADDR_BITS-1:0] d, input logic w);
        issue_valid = 1'b1;
        issue_src0  = s0;
        issue_src1  = s1;
        issue_dst   = d;
        issue_wb    = w;
    endtask

    // Execute-stage monitor: every accepted operand bundle is compared in order.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rand_mode && ex_valid && ex_ready) begin
            if (expq.size() == 0) begin
                check_output("ex_unexpected", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                check_output("rand_op0", 32'(ex_op0), 32'(e.op0));
                check_output("rand_op1", 32'(ex_op1), 32'(e.op1));
                check_output("rand_dst", 32'(ex_dst), 32'(e.dst));
                check_output("rand_wb",  32'(ex_wb),  32'(e.wb));
                if (e.wb) wbq.push_back('{addr: e.dst, data: e.wdata});
            end
        end
    end

    task automatic issue_driver();
        logic [ADDR_BITS-1:0] s0, s1, d;
        logic                 w;
        logic [DATA_BITS-1:0] wd;
        bit                   accepted;
        for (int k = 0; k < NUM_RAND; k++) begin
            s0 = ADDR_BITS'($urandom_range(0, NUM_REGS - 1));
            s1 = ADDR_BITS'($urandom_range(0, NUM_REGS - 1));
            d  = ADDR_BITS'($urandom_range(0, NUM_REGS - 1));
            w  = ($urandom_range(0, 3) != 0);
            // Avoid two outstanding writers of one register; the scoreboard only tracks RAW.
            if (w && pending[d] != 0) w = 1'b0;
            wd = DATA_BITS'($urandom);
            repeat ($urandom_range(0, 2)) cyc();
            apply_stimulus(s0, s1, d, w);
            accepted = 1'b0;
            for (int t = 0; t < 300 && !accepted; t++) begin
                @(negedge clk);
                if (issue_ready) accepted = 1'b1;
                @(posedge clk);
                #1;
            end
            issue_valid = 1'b0;
            if (!accepted) begin
                check_output("issue_timeout", 32'd0, 32'd1);
                break;
            end
            expq.push_back('{op0: arch[s0], op1: arch[s1], dst: d, wb: w, wdata: wd});
            if (w) begin
                arch[d] = wd;
                pending[d]++;
            end
        end
        issue_done = 1'b1;
    endtask

    task automatic exec_driver();
        wbreq_t r;
        int     cycles = 0;
        while (!issue_done || expq.size() > 0 || wbq.size() > 0 || wb_valid) begin
            cyc();
            cycles++;
            if (cycles > 20000) begin
                check_output("drain_timeout", 32'd0, 32'd1);
                break;
            end
            ex_ready = ($urandom_range(0, 3) != 0);
            if (wbq.size() > 0 && $urandom_range(0, 1) == 1) begin
                r        = wbq.pop_front();
                wb_valid = 1'b1;
                wb_addr  = r.addr;
                wb_data  = r.data;
                pending[r.addr]--;
            end else begin
                wb_valid = 1'b0;
            end
        end
        ex_ready = 1'b0;
        wb_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; issue_valid = 1'b0; issue_src0 = '0; issue_src1 = '0;
        issue_dst = '0; issue_wb = 1'b0; ex_ready = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        for (int i = 0; i < NUM_REGS; i++) pending[i] = 0;

        // Reset holds off writebacks and the issue port.
        wb_valid = 1'b1; wb_addr = 3'd2; wb_data = 8'h77;
        cyc();
        init_rf = 1'b0;
        cyc();
        check_output("rst_wr_enable", 32'(wr_enable), 32'd0);
        check_output("rst_ex_valid", 32'(ex_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_issue_ready", 32'(issue_ready), 32'd0);
        check_output("rst_rd0_enable", 32'(rd0_enable), 32'd0);
        check_output("rst_r2_untouched", 32'(rf[2]), 32'h23);
        reset = 1'b1; wb_valid = 1'b0;
        cyc();
        check_output("idle_issue_ready", 32'(issue_ready), 32'd1);

        // Basic fetch with two-cycle latency.
        wb_valid = 1'b1; wb_addr = 3'd1; wb_data = 8'h12;
        #1 check_output("wr_enable_pass", 32'(wr_enable), 32'd1);
        cyc();
        wb_addr = 3'd2; wb_data = 8'h34;
        cyc();
        wb_valid = 1'b0;
        apply_stimulus(3'd1, 3'd2, 3'd3, 1'b1);
        cyc();
        issue_valid = 1'b0;
        check_output("fetch_rd0_enable", 32'(rd0_enable), 32'd1);
        check_output("fetch_rd1_addr", 32'(rd1_addr), 32'd2);
        check_output("fetch_ex_valid", 32'(ex_valid), 32'd0);
        cyc();
        check_output("t2_ex_valid", 32'(ex_valid), 32'd1);
        check_output("t2_op0", 32'(ex_op0), 32'h12);
        check_output("t2_op1", 32'(ex_op1), 32'h34);
        check_output("t2_dst", 32'(ex_dst), 32'd3);
        check_output("t2_busy", 32'(busy), 32'h08);
        check_output("t2_issue_ready", 32'(issue_ready), 32'd0);
        ex_ready = 1'b1;
        cyc();
        ex_ready = 1'b0;
        check_output("t2_drain", 32'(ex_valid), 32'd0);

        // RAW stall on r3, released by a bypassed writeback.
        apply_stimulus(3'd3, 3'd0, 3'd5, 1'b0);
        cyc();
        issue_valid = 1'b0;
        cyc();
        check_output("stall_issue_ready", 32'(issue_ready), 32'd0);
        check_output("stall_rd0_enable", 32'(rd0_enable), 32'd1);
        check_output("stall_rd0_addr", 32'(rd0_addr), 32'd3);
        check_output("stall_ex_valid", 32'(ex_valid), 32'd0);
        wb_valid = 1'b1; wb_addr = 3'd3; wb_data = 8'h5A;
        cyc();
        wb_valid = 1'b0;
        check_output("t3_ex_valid", 32'(ex_valid), 32'd1);
        check_output("t3_op0_bypass", 32'(ex_op0), 32'h5A);
        check_output("t3_op1", 32'(ex_op1), 32'h01);
        check_output("t3_busy", 32'(busy), 32'h00);
        check_output("t3_r3_written", 32'(rf[3]), 32'h5A);

        // Held output under backpressure, then back-to-back issue.
        apply_stimulus(3'd4, 3'd5, 3'd4, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_output("hold_ex_valid", 32'(ex_valid), 32'd1);
            check_output("hold_op0", 32'(ex_op0), 32'h5A);
            check_output("hold_dst", 32'(ex_dst), 32'd5);
            check_output("hold_issue_ready", 32'(issue_ready), 32'd0);
        end
        ex_ready = 1'b1;
        #1 check_output("b2b_issue_ready", 32'(issue_ready), 32'd1);
        cyc();
        ex_ready = 1'b0; issue_valid = 1'b0;
        check_output("b2b_ex_valid", 32'(ex_valid), 32'd0);
        check_output("b2b_rd0_enable", 32'(rd0_enable), 32'd1);
        check_output("b2b_rd0_addr", 32'(rd0_addr), 32'd4);

        // Same-edge set and clear of busy[4]: set wins.
        wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 8'hC3;
        cyc();
        wb_valid = 1'b0;
        check_output("t5_busy", 32'(busy), 32'h10);
        check_output("t5_r4_written", 32'(rf[4]), 32'hC3);
        check_output("t5_op0_bypass", 32'(ex_op0), 32'hC3);
        check_output("t5_op1", 32'(ex_op1), 32'h56);
        check_output("t5_ex_wb", 32'(ex_wb), 32'd1);
        ex_ready = 1'b1;
        cyc();
        ex_ready = 1'b0;

        // Fill the scoreboard, stall, then reset mid-fetch.
        wb_valid = 1'b1; wb_addr = 3'd4; wb_data = 8'h44;
        cyc();
        wb_valid = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            apply_stimulus(ADDR_BITS'(i), ADDR_BITS'(i), ADDR_BITS'(i), 1'b1);
            cyc();
            issue_valid = 1'b0;
            cyc();
            ex_ready = 1'b1;
            cyc();
            ex_ready = 1'b0;
        end
        check_output("t6_busy_full", 32'(busy), 32'hFF);
        apply_stimulus(3'd2, 3'd2, 3'd0, 1'b0);
        cyc();
        issue_valid = 1'b0;
        cyc();
        check_output("t6_stalled", 32'(rd0_enable), 32'd1);
        reset = 1'b0;
        #1 check_output("t6_rst_issue_ready", 32'(issue_ready), 32'd0);
        cyc();
        check_output("t6_busy_cleared", 32'(busy), 32'd0);
        check_output("t6_ex_valid", 32'(ex_valid), 32'd0);
        reset = 1'b1;
        #1;
        check_output("t6_idle", 32'(issue_ready), 32'd1);
        check_output("t6_rd0_enable", 32'(rd0_enable), 32'd0);

        // Random traffic against the in-order architectural model.
        for (int i = 0; i < NUM_REGS; i++) arch[i] = rf[i];
        rand_mode = 1'b1;
        fork
            issue_driver();
            exec_driver();
        join
        cyc();
        rand_mode = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            check_output("final_reg", 32'(rf[i]), 32'(arch[i]));
        end
        check_output("final_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
